// File: rtl/adder_stream_stage.sv
// adder_stream_stage: valid/ready wrapper around a 64-bit Brent-Kung adder with an output FIFO
module brent_kung64b (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [64:0] s
);
    logic [63:0] x, g, p;
    always_comb begin
        x = a ^ b;
        g = a & b;
        p = x;
        for (int l = 0; l < 6; l++)
            for (int i = 0; i < 64; i++)
                if ((i + 1) % (2 << l) == 0) begin
                    g[i] = g[i] | (p[i] & g[(i - (1 << l)) & 63]);
                    p[i] = p[i] & p[(i - (1 << l)) & 63];
                end
        // down-sweep fills in the prefixes the up-sweep tree skipped
        for (int l = 4; l >= 0; l--)
            for (int i = 0; i < 64; i++)
                if ((i + 1) % (2 << l) == (1 << l) && i >= (2 << l)) begin
                    g[i] = g[i] | (p[i] & g[(i - (1 << l)) & 63]);
                    p[i] = p[i] & p[(i - (1 << l)) & 63];
                end
        s = {g[63], x ^ {g[62:0], 1'b0}};
    end
endmodule

module adder_stream_stage #(
    parameter int WIDTH     = 64,
    parameter int OUT_DEPTH = 2,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic [CNT_W-1:0] txn_count
);
    localparam int AW = $clog2(OUT_DEPTH);
    logic             s1_vld;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   mem [OUT_DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [AW:0]      count;
    logic             push, pop, accept;

    brent_kung64b u_add (.a(a_q), .b(b_q), .s(sum));

    // count never exceeds OUT_DEPTH (a power of two), so its top bit alone means full
    assign out_valid = count != '0;
    assign out_sum   = mem[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign push      = s1_vld & (~count[AW] | pop);
    assign in_ready  = ~s1_vld | push;
    assign accept    = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            txn_count <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (accept) begin
                a_q    <= in_a;
                b_q    <= in_b;
                s1_vld <= 1'b1;
            end else if (push) begin
                s1_vld <= 1'b0;
            end
            if (push) begin
                mem[wr_ptr] <= sum;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                txn_count <= txn_count + 1'b1;
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
endmodule

// File: tb/tb_adder_stream_stage.sv
// tb_adder_stream_stage: random and directed stimulus checked against a queue-based model
module tb_adder_stream_stage;
    localparam int DEPTH = 2;
    logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_a, in_b;
    logic [64:0] out_sum;
    logic [31:0] txn_count;
    int          vectors = 0, errors = 0;
    logic [64:0] q [$];
    logic [64:0] popped [$];
    logic        s1v = 0;
    logic [64:0] s1sum = '0;
    logic [31:0] cnt = '0;
    time         t0, t1;

    adder_stream_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .txn_count(txn_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // model: one operand slot feeding a DEPTH-entry FIFO, advanced once per clock
    initial forever begin
        logic pop_m, push_m, rdy_m;
        @(negedge clk);
        #2;
        if (rst) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_sum", out_sum, 0);
            chk("rst_txn_count", txn_count, 0);
            s1v = 0;
            q.delete();
            cnt = 0;
        end else begin
            pop_m  = q.size() > 0 && out_ready;
            push_m = s1v && (q.size() < DEPTH || pop_m);
            rdy_m  = !s1v || push_m;
            chk("in_ready", in_ready, rdy_m);
            chk("out_valid", out_valid, q.size() > 0);
            if (q.size() > 0) chk("out_sum", out_sum, q[0]);
            chk("txn_count", txn_count, cnt);
            if (out_valid && out_ready) popped.push_back(out_sum);
            if (pop_m) begin
                void'(q.pop_front());
                cnt++;
            end
            if (push_m) q.push_back(s1sum);
            if (in_valid && rdy_m) begin
                s1v   = 1;
                s1sum = {1'b0, in_a} + {1'b0, in_b};
            end else if (push_m) s1v = 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic send(input logic [63:0] a, input logic [63:0] b);
        int n = 0;
        in_valid = 1;
        in_a = a;
        in_b = b;
        #3;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (n == 20) chk("send_timeout", 0, 1);
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        popped.delete();
    endtask

    initial begin
        logic [63:0] a, b;
        rst = 1; in_valid = 0; in_a = 0; in_b = 0; out_ready = 0;
        #1;
        chk("init_out_valid", out_valid, 0);
        chk("init_in_ready", in_ready, 1);
        chk("init_out_sum", out_sum, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        // single op with full carry out
        send('1, 64'd1);
        @(negedge clk);
        #3;
        chk("single_valid", out_valid, 1);
        chk("single_sum", out_sum, 65'h1_0000_0000_0000_0000);
        // backpressure, then one cycle of simultaneous push/pop on a full FIFO
        do_reset();
        out_ready = 0;
        for (int k = 1; k <= 3; k++) send(64'(k), 64'(k));
        in_valid = 1; in_a = 4; in_b = 4;
        repeat (3) begin
            #3;
            chk("bp_stall_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1;
        #3;
        chk("full_pushpop_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 0; out_ready = 0;
        #3;
        chk("full_after_valid", out_valid, 1);
        chk("full_after_sum", out_sum, 65'd4);
        chk("full_after_stall", in_ready, 0);
        chk("full_after_txn", txn_count, 1);
        @(negedge clk);
        out_ready = 1;
        repeat (4) @(negedge clk);
        #3;
        chk("bp_popped_n", 65'(popped.size()), 4);
        for (int k = 0; k < 4 && k < popped.size(); k++) chk("bp_order", popped[k], 65'(2 * (k + 1)));
        chk("bp_txn", txn_count, 4);
        // streaming
        do_reset();
        out_ready = 1;
        t0 = $time;
        for (int i = 0; i < 200; i++) begin
            a = i == 0 ? 64'd0 : i == 1 ? '1 : {$urandom(), $urandom()};
            b = i == 0 ? 64'd0 : i == 1 ? '1 : {$urandom(), $urandom()};
            send(a, b);
        end
        t1 = $time;
        chk("stream_cycles", 65'((t1 - t0) / 10), 200);
        repeat (2) @(negedge clk);
        #3;
        chk("stream_txn", txn_count, 200);
        chk("stream_popped_n", 65'(popped.size()), 200);
        if (popped.size() > 1) begin
            chk("stream_zero", popped[0], 0);
            chk("stream_max", popped[1], 65'h1_FFFF_FFFF_FFFF_FFFE);
        end
        // mid-stream reset discards everything in flight
        @(negedge clk);
        out_ready = 0;
        send(64'd10, 64'd10);
        send(64'd20, 64'd20);
        send(64'd30, 64'd30);
        rst = 1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_sum", out_sum, 0);
        chk("mid_rst_txn", txn_count, 0);
        @(negedge clk);
        rst = 0;
        popped.delete();
        out_ready = 1;
        send(64'd5, 64'd7);
        repeat (4) @(negedge clk);
        #3;
        chk("mid_popped_n", 65'(popped.size()), 1);
        if (popped.size() > 0) chk("mid_sum", popped[0], 65'd12);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
